msg_schedule: RTL and testbench

MSG_SCHEDULE -- requirements
Module: msg_schedule

---
 rtl/sha256_pkg.sv | 33 +++
 rtl/sha256_sigma0.sv | 13 +
 rtl/sha256_sigma1.sv | 11 +
 rtl/msg_schedule.sv | 108 ++++++++++
 tb/tb_msg_schedule.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule FSM states and the rotate/shift primitives.
package sha256_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned MAX_WORDS   = 64;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned CNT_W       = 4;

  localparam int unsigned S0_ROT_A = 7;
  localparam int unsigned S0_ROT_B = 18;
  localparam int unsigned S0_SHR   = 3;
  localparam int unsigned S1_ROT_A = 17;
  localparam int unsigned S1_ROT_B = 19;
  localparam int unsigned S1_SHR   = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } sched_state_e;

  // Rotate right by n (n in 1..WORD_W-1).
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t shr(input word_t x, input int unsigned n);
    return x >> n;
  endfunction

endpackage

// File: rtl/sha256_sigma0.sv
// Small sigma0 of the message schedule; output forced to zero while start is low.
module sha256_sigma0
  import sha256_pkg::*;
(
  input  logic              start,
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y_c
);

  assign y_c = start ? (rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ shr(x, S0_SHR))
                     : '0;

endmodule

// File: rtl/sha256_sigma1.sv
// Small sigma1 of the message schedule (purely combinational).
module sha256_sigma1
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y_c
);

  assign y_c = rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ shr(x, S1_SHR);

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: loads 16 message words, then streams W[0..NUM_WORDS-1]
// from a 16-word sliding window with valid/ready handshakes on both sides.
module msg_schedule
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [IDX_W-1:0]  out_index,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(BLOCK_WORDS - 1);

  sched_state_e       state;
  logic [CNT_W-1:0]   k;
  logic [IDX_W-1:0]   t;
  logic [WORD_W-1:0]  w [BLOCK_WORDS];
  logic [WORD_W-1:0]  s0_c;
  logic [WORD_W-1:0]  s1_c;
  logic [WORD_W-1:0]  w_new_c;

  sha256_sigma0 u_sigma0 (
    .start (1'b1),
    .x     (w[1]),
    .y_c   (s0_c)
  );

  sha256_sigma1 u_sigma1 (
    .x   (w[14]),
    .y_c (s1_c)
  );

  // Next schedule word entering the top of the window (mod 2^32).
  assign w_new_c = s1_c + w[9] + s0_c + w[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      k         <= '0;
      t         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_index <= '0;
      busy      <= 1'b0;
      for (int unsigned j = 0; j < BLOCK_WORDS; j++) begin
        w[CNT_W'(j)] <= '0;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            w[k] <= in_word;
            busy <= 1'b1;
            if (k == LAST_LOAD) begin
              // w[0] already holds M0 from the first accepted word.
              state     <= ST_EMIT;
              k         <= '0;
              t         <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_word  <= w[0];
              out_index <= '0;
            end else begin
              k <= k + CNT_W'(1);
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            for (int unsigned j = 0; j < BLOCK_WORDS - 1; j++) begin
              w[CNT_W'(j)] <= w[CNT_W'(j + 1)];
            end
            w[LAST_LOAD] <= w_new_c;
            if (t == LAST_IDX) begin
              state     <= ST_LOAD;
              t         <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_word  <= '0;
              out_index <= '0;
              busy      <= 1'b0;
            end else begin
              t         <= t + IDX_W'(1);
              out_index <= t + IDX_W'(1);
              out_word  <= w[1];
            end
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule: reference schedule model, stall/handshake
// monitor, and directed sequences around reset, back-to-back blocks and NUM_WORDS=16.
module tb_msg_schedule;

  typedef logic [31:0] blk_t [16];
  typedef struct {
    int          idx;
    logic [31:0] w;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_word, out_word;
  logic [5:0]  out_index;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_in_word, b_out_word;
  logic [5:0]  b_out_index;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [37:0] gotq [$];
  logic [37:0] gotb [$];
  int          h63q [$];
  logic [31:0] exp_w [64];
  logic        prev_stall = 1'b0;
  logic [37:0] prev_out = '0;
  bit          w0_pending = 1'b0;
  int          w0_cyc = -1;

  msg_schedule #(.NUM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_index(out_index), .busy(busy)
  );

  msg_schedule #(.NUM_WORDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_word(b_in_word), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_word(b_out_word), .out_index(b_out_index), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return 32'(d >> n);
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  // Textbook schedule recurrence over the whole 64-word array.
  task automatic build_model(input blk_t m);
    for (int i = 0; i < 16; i++) exp_w[i] = m[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ss1(exp_w[i-2]) + exp_w[i-7] + ss0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic compare_block(input blk_t m, input int base, input int n);
    build_model(m);
    for (int i = 0; i < n; i++) begin
      if (base + i < gotq.size())
        check($sformatf("word%0d", base + i), 64'(gotq[base + i]), 64'({6'(i), exp_w[i]}));
      else
        check($sformatf("missing%0d", base + i), 64'(gotq.size()), 64'(base + n));
    end
  endtask

  // Handshake logger and stall-stability / in_ready-during-EMIT checker.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 64'({out_valid, out_index, out_word}), 64'({1'b1, prev_out}));
      if (out_valid)
        check("in_ready_in_emit", 64'(in_ready), 64'd0);
      if (w0_pending && out_valid && out_index == 6'd0) begin
        w0_cyc = cyc;
        w0_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        gotq.push_back({out_index, out_word});
        if (out_index == 6'd63) begin
          h63q.push_back(cyc);
          w0_pending = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_index, out_word};
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) gotb.push_back({b_out_index, b_out_word});
  end

  task automatic load_block(input blk_t m, input int n, input bit rnd);
    int  i = 0;
    int  budget = 0;
    bit  acc;
    while (i < n && budget < 200) begin
      in_valid  = 1'b1;
      in_word   = m[i];
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      budget++;
    end
    in_valid = 1'b0;
    check("load_count", 64'(i), 64'(n));
  endtask

  task automatic collect(input int n, input bit rnd);
    int budget = 0;
    while (gotq.size() < n && budget < 1000) begin
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      @(posedge clk); #1;
      budget++;
    end
    check("collect_count", 64'(gotq.size()), 64'(n));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  blk_t        abc, r1, junk, rb;
  logic [31:0] stream [32];
  vec_t        tab [5];
  int          pos, budget;
  bit          acc;

  initial begin
    tab[0] = '{0,  32'h61626380};
    tab[1] = '{1,  32'h00000000};
    tab[2] = '{15, 32'h00000018};
    tab[3] = '{16, 32'h61626380};
    tab[4] = '{17, 32'h000F0000};
    for (int i = 0; i < 16; i++) begin
      abc[i]  = 32'h0;
      r1[i]   = $urandom;
      junk[i] = $urandom;
      rb[i]   = $urandom;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_word = '0; b_out_ready = 1'b0;

    // Reset state and in_ready rising on the first edge after release.
    repeat (3) @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_word", 64'(out_word), 64'd0);
    check("rst_out_index", 64'(out_index), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("in_ready_after_release", 64'(in_ready), 64'd1);
    check("busy_idle", 64'(busy), 64'd0);

    // "abc" block, consumer always ready.
    gotq.delete();
    load_block(abc, 16, 1'b0);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_index", 64'(out_index), 64'd0);
    check("lat_out_word", 64'(out_word), 64'h61626380);
    check("lat_busy", 64'(busy), 64'd1);
    collect(64, 1'b0);
    check("end_in_ready", 64'(in_ready), 64'd1);
    check("end_out_valid", 64'(out_valid), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    compare_block(abc, 0, 64);
    for (int i = 0; i < 5; i++)
      if (tab[i].idx < gotq.size())
        check($sformatf("tab_w%0d", tab[i].idx), 64'(gotq[tab[i].idx][31:0]), 64'(tab[i].w));

    // Same block under random backpressure.
    gotq.delete();
    load_block(abc, 16, 1'b1);
    collect(64, 1'b1);
    compare_block(abc, 0, 64);

    // Two blocks back to back with in_valid held high throughout.
    for (int i = 0; i < 16; i++) begin
      stream[i] = abc[i];
      stream[16 + i] = r1[i];
    end
    gotq.delete(); h63q.delete(); w0_pending = 1'b0; w0_cyc = -1;
    pos = 0; budget = 0;
    while ((pos < 32 || gotq.size() < 128) && budget < 1000) begin
      in_valid  = (pos < 32);
      in_word   = stream[pos < 32 ? pos : 0];
      out_ready = 1'b1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc && pos < 32) pos++;
      budget++;
    end
    in_valid = 1'b0;
    check("b2b_count", 64'(gotq.size()), 64'd128);
    if (h63q.size() > 0)
      check("b2b_gap", 64'(w0_cyc - h63q[0]), 64'd17);
    else
      check("b2b_no_w63", 64'(h63q.size()), 64'd1);
    compare_block(abc, 0, 64);
    compare_block(r1, 64, 64);
    w0_pending = 1'b0;

    // Reset after 8 loaded words, then a clean block.
    gotq.delete();
    load_block(junk, 8, 1'b0);
    pulse_reset();
    load_block(abc, 16, 1'b0);
    collect(64, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    check("abort_count", 64'(gotq.size()), 64'd64);
    compare_block(abc, 0, 64);

    // Reset while emitting t = 30.
    gotq.delete();
    load_block(abc, 16, 1'b0);
    out_ready = 1'b1;
    budget = 0;
    while (out_index != 6'd30 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check("t30_reached", 64'(out_index), 64'd30);
    rst_n = 1'b0; #1;
    check("t30_out_valid", 64'(out_valid), 64'd0);
    check("t30_out_word", 64'(out_word), 64'd0);
    check("t30_out_index", 64'(out_index), 64'd0);
    check("t30_busy", 64'(busy), 64'd0);
    check("t30_emitted", 64'(gotq.size()), 64'd30);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t30_in_ready", 64'(in_ready), 64'd1);
    gotq.delete();
    load_block(abc, 16, 1'b0);
    collect(64, 1'b0);
    compare_block(abc, 0, 64);

    // NUM_WORDS = 16 instance passes the message straight through.
    gotb.delete();
    pos = 0; budget = 0;
    b_out_ready = 1'b1;
    while ((pos < 16 || gotb.size() < 16) && budget < 200) begin
      b_in_valid = (pos < 16);
      b_in_word  = rb[pos < 16 ? pos : 0];
      acc = b_in_ready;
      @(posedge clk); #1;
      if (acc && pos < 16) pos++;
      budget++;
    end
    b_in_valid = 1'b0;
    check("n16_count", 64'(gotb.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      if (i < gotb.size())
        check($sformatf("n16_word%0d", i), 64'(gotb[i]), 64'({6'(i), rb[i]}));
    check("n16_out_valid", 64'(b_out_valid), 64'd0);
    check("n16_in_ready", 64'(b_in_ready), 64'd1);
    check("n16_busy", 64'(b_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
